// File: rtl/matriz_pkg.sv
// matriz_pkg: shared sizes, load-stage states and error codes for the matrix stages
package matriz_pkg;
  localparam int DIM = 5;
  localparam int EW = 8;
  localparam int MAT_W = DIM*DIM*EW;
  typedef enum logic [1:0] {LOAD, PEND, RUN, DRAIN} carga_state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_FRAME = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
endpackage

// File: rtl/matriz_watchdog.sv
// matriz_watchdog: clear/enable cycle counter that saturates at its terminal count
module matriz_watchdog #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  // tc flags the LIMIT-th enabled cycle, counting the current one
  assign tc = cnt == W'(LIMIT - 1);
  // count enabled cycles, holding once the terminal count is reached
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/matriz_carga5x5.sv
// matriz_carga5x5: streams a 5x5 matrix into a flat operand and sequences the determinant unit
module matriz_carga5x5 #(
  parameter int DIM = matriz_pkg::DIM,
  parameter int EW = matriz_pkg::EW,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [EW-1:0]         in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DIM*DIM*EW-1:0] matriz_A,
  output logic                  start,
  input  logic                  done,
  input  logic [EW-1:0]         det,
  output logic                  res_valid,
  output logic [EW-1:0]         res_data,
  input  logic                  res_ready,
  output logic [1:0]            err
);
  import matriz_pkg::*;
  localparam int N = DIM*DIM;
  localparam int IW = $clog2(N);
  carga_state_t state, ns;
  logic [IW-1:0] idx;
  logic accept, at_last, frame_ok, frame_err, buf_free, wd_tc, timeout;
  assign accept = in_valid && in_ready;
  assign at_last = idx == IW'(N - 1);
  assign frame_err = accept && (in_last != at_last);
  assign frame_ok = accept && in_last && at_last;
  assign buf_free = !res_valid || res_ready;
  assign timeout = state == RUN && wd_tc && !done;
  matriz_watchdog #(.LIMIT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != RUN),
    .en(state == RUN),
    .tc(wd_tc)
  );
  // next state; done takes priority over the watchdog in RUN
  always_comb begin
    ns = state;
    case (state)
      LOAD:    if (frame_ok) ns = buf_free ? RUN : PEND;
      PEND:    if (buf_free) ns = RUN;
      RUN:     if (done || wd_tc) ns = DRAIN;
      DRAIN:   if (!done) ns = LOAD;
      default: ns = LOAD;
    endcase
  end
  // state plus registered handshake/request decodes and the one-cycle error pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= LOAD;
      in_ready <= 1'b0;
      start <= 1'b0;
      err <= ERR_NONE;
    end else begin
      state <= ns;
      in_ready <= ns == LOAD;
      start <= ns == RUN;
      err <= frame_err ? ERR_FRAME : timeout ? ERR_TIMEOUT : ERR_NONE;
    end
  // operand assembly; a malformed frame restarts at element 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      matriz_A <= '0;
    end else if (accept) begin
      matriz_A[idx*EW +: EW] <= in_data;
      idx <= (frame_err || frame_ok) ? '0 : idx + 1'b1;
    end
  // one-entry result buffer, only filled from RUN which is entered with it free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data <= '0;
    end else if (state == RUN && done) begin
      res_valid <= 1'b1;
      res_data <= det;
    end else if (res_valid && res_ready) res_valid <= 1'b0;
endmodule

// File: tb/tb_matriz_carga5x5.sv
// tb_matriz_carga5x5: directed checks of frame loading, run sequencing, result buffer and watchdog
module tb_matriz_carga5x5;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_last = 0, in_ready;
  logic [7:0] in_data = 0;
  logic [199:0] matriz_A;
  logic start, done = 0, res_valid, res_ready = 0;
  logic [7:0] det = 0, res_data;
  logic [1:0] err;
  logic [7:0] frame [25];
  logic model_en = 1;
  logic [7:0] model_det = 8'h01;
  int model_lat = 12, mcnt = 0;
  int n_cmp = 0, n_bad = 0;

  matriz_carga5x5 #(.DIM(5), .EW(8), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .matriz_A(matriz_A), .start(start), .done(done), .det(det),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .err(err)
  );

  always #5 clk = ~clk;

  // determinant unit model: done after model_lat full cycles of start, clears when start drops
  always @(negedge clk) begin
    mcnt = start ? mcnt + 1 : 0;
    done = model_en && mcnt > model_lat;
    det = done ? model_det : 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  function automatic logic [199:0] expected_operand();
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = frame[i];
    return v;
  endfunction

  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 25; i++) beat(frame[i], i == 24);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !in_ready; i++) begin @(posedge clk); #1; end
  endtask

  task automatic count_start(input logic [199:0] exp, output int n, output int unstable);
    n = 0; unstable = 0;
    while (start && n < 100) begin
      if (matriz_A !== exp) unstable++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", start); end
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_cmp++; if (matriz_A !== '0) begin n_bad++; $display("FAIL reset_matriz: got %h want 0", matriz_A); end
    n_cmp++; if (err !== 2'b00 || res_data !== 8'h00) begin n_bad++; $display("FAIL reset_err_data: got %b/%h want 00/00", err, res_data); end
    rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_identity();
    int n, bad;
    for (int i = 0; i < 25; i++) frame[i] = (i % 6 == 0) ? 8'h01 : 8'h00;
    model_det = 8'h01; model_lat = 12; res_ready = 0;
    send_frame();
    n_cmp++; if (matriz_A[7:0] !== 8'h01 || matriz_A[55:48] !== 8'h01) begin n_bad++; $display("FAIL id_diag: got %h/%h want 01/01", matriz_A[7:0], matriz_A[55:48]); end
    n_cmp++; if (matriz_A !== expected_operand()) begin n_bad++; $display("FAIL id_operand: got %h want %h", matriz_A, expected_operand()); end
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL id_start_rise: got %b want 1", start); end
    count_start(expected_operand(), n, bad);
    n_cmp++; if (n != 13) begin n_bad++; $display("FAIL id_start_len: got %0d want 13", n); end
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 8'h01) begin n_bad++; $display("FAIL id_result: got %b/%h want 1/01", res_valid, res_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL id_drain_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL id_load_ready: got %b want 1", in_ready); end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL id_consume: got %b want 0", res_valid); end
  endtask

  task automatic test_hold();
    int n, bad;
    for (int i = 0; i < 25; i++) frame[i] = (i % 6 == 0) ? 8'h01 : 8'h00;
    frame[7] = 8'hA5;
    model_det = 8'h3C;
    wait_ready();
    send_frame();
    n_cmp++; if (matriz_A[63:56] !== 8'hA5) begin n_bad++; $display("FAIL hold_elem7: got %h want a5", matriz_A[63:56]); end
    count_start(expected_operand(), n, bad);
    n_cmp++; if (bad != 0 || n != 13) begin n_bad++; $display("FAIL hold_stable: got %0d unstable of %0d want 0 of 13", bad, n); end
    n_cmp++; if (res_data !== 8'h3C) begin n_bad++; $display("FAIL hold_result: got %h want 3c", res_data); end
  endtask

  task automatic test_pend();
    int n, bad;
    for (int i = 0; i < 25; i++) frame[i] = 8'(i + 1);
    model_det = 8'h5A;
    wait_ready();
    send_frame();
    n_cmp++; if (start !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL pend_enter: got start %b ready %b want 0 0", start, in_ready); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (start !== 1'b0 || res_valid !== 1'b1 || res_data !== 8'h3C) begin n_bad++; $display("FAIL pend_hold: got %b/%b/%h want 0/1/3c", start, res_valid, res_data); end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    n_cmp++; if (start !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'h3C) begin n_bad++; $display("FAIL pend_release: got %b/%b/%h want 1/0/3c", start, res_valid, res_data); end
    count_start(expected_operand(), n, bad);
    n_cmp++; if (n != 13 || res_data !== 8'h5A || res_valid !== 1'b1) begin n_bad++; $display("FAIL pend_result: got %0d/%h/%b want 13/5a/1", n, res_data, res_valid); end
    res_ready = 1;
  endtask

  task automatic test_frame_err();
    int n, bad;
    wait_ready();
    for (int i = 0; i < 10; i++) beat(8'hEE, i == 9);
    n_cmp++; if (err !== 2'b01) begin n_bad++; $display("FAIL ferr_early: got %b want 01", err); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 2'b00 || start !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL ferr_early_after: got %b/%b/%b want 00/0/1", err, start, in_ready); end
    for (int i = 0; i < 25; i++) beat(8'hDD, 1'b0);
    n_cmp++; if (err !== 2'b01 || start !== 1'b0) begin n_bad++; $display("FAIL ferr_nolast: got %b/%b want 01/0", err, start); end
    for (int i = 0; i < 25; i++) frame[i] = 8'(8'h80 + i);
    model_det = 8'h77;
    send_frame();
    n_cmp++; if (start !== 1'b1 || err !== 2'b00 || matriz_A !== expected_operand()) begin n_bad++; $display("FAIL ferr_recover: got %b/%b/%h want 1/00/%h", start, err, matriz_A, expected_operand()); end
    count_start(expected_operand(), n, bad);
    n_cmp++; if (n != 13 || res_data !== 8'h77) begin n_bad++; $display("FAIL ferr_result: got %0d/%h want 13/77", n, res_data); end
  endtask

  task automatic test_timeout();
    int n, bad;
    wait_ready();
    model_en = 0;
    send_frame();
    count_start(expected_operand(), n, bad);
    n_cmp++; if (n != 20) begin n_bad++; $display("FAIL to_start_len: got %0d want 20", n); end
    n_cmp++; if (err !== 2'b10 || res_valid !== 1'b0) begin n_bad++; $display("FAIL to_err: got %b/%b want 10/0", err, res_valid); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 2'b00 || res_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL to_after: got %b/%b/%b want 00/0/1", err, res_valid, in_ready); end
    model_en = 1; model_lat = 19; model_det = 8'hC3;
    send_frame();
    count_start(expected_operand(), n, bad);
    n_cmp++; if (n != 20 || err !== 2'b00 || res_valid !== 1'b1 || res_data !== 8'hC3) begin n_bad++; $display("FAIL to_coincide: got %0d/%b/%b/%h want 20/00/1/c3", n, err, res_valid, res_data); end
    model_lat = 12;
  endtask

  task automatic test_reset_mid_run();
    wait_ready();
    send_frame();
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL rst_pre_start: got %b want 1", start); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (start !== 1'b0 || res_valid !== 1'b0 || matriz_A !== '0) begin n_bad++; $display("FAIL rst_async: got %b/%b/%h want 0/0/0", start, res_valid, matriz_A); end
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || start !== 1'b0) begin n_bad++; $display("FAIL rst_release: got %b/%b want 1/0", in_ready, start); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_hold();
    test_pend();
    test_frame_err();
    test_timeout();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
